// File: rtl/sr_flip_flop.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sr_flip_flop
//  Description : Clocked SR storage element replicated per bit. Provides
//                complementary outputs and a registered flag for cycles in
//                which set and reset were requested together. The action on
//                simultaneous set/reset is fixed by BOTH_POLICY.
//  Revision    : 1.0  - initial release
// ============================================================================
module sr_flip_flop #(
  parameter int WIDTH       = 1,
  parameter bit RESET_VAL   = 1'b0,
  parameter int BOTH_POLICY = 0
) (
  input  logic             clk,
  input  logic             reset,    // asynchronous, active-low
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] illegal
);

  // Simultaneous set/reset actions
  localparam int c_POL_HOLD   = 0;
  localparam int c_POL_SET    = 1;
  localparam int c_POL_CLEAR  = 2;
  localparam int c_POL_TOGGLE = 3;

  // Parameter sanity: refuse to build a block with no bits or an unknown policy
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "sr_flip_flop: WIDTH must be at least 1");
  end
  if ((BOTH_POLICY < c_POL_HOLD) || (BOTH_POLICY > c_POL_TOGGLE)) begin : g_bad_policy
    $fatal(1, "sr_flip_flop: BOTH_POLICY must be in 0..3");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] illegal_q;
  logic [WIDTH-1:0] illegal_d;

  // Per-bit next-state: hold by default, then apply the set/reset request
  always_comb begin
    q_d       = q_q;
    illegal_d = s & r;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        2'b11: begin
          if (BOTH_POLICY == c_POL_SET) begin
            q_d[i] = 1'b1;
          end else if (BOTH_POLICY == c_POL_CLEAR) begin
            q_d[i] = 1'b0;
          end else if (BOTH_POLICY == c_POL_TOGGLE) begin
            q_d[i] = ~q_q[i];
          end else begin
            q_d[i] = q_q[i];
          end
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // State register; reset forces the stored value and clears the flag at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q       <= {WIDTH{RESET_VAL}};
      illegal_q <= '0;
    end else begin
      q_q       <= q_d;
      illegal_q <= illegal_d;
    end
  end

  // qbar is derived from the register so it can never disagree with q
  assign q       = q_q;
  assign qbar    = ~q_q;
  assign illegal = illegal_q;

  // Unknown requests are passed through untouched, so flag them loudly
  a_s_known : assert property (@(posedge clk) disable iff (!reset) !$isunknown(s))
    else $error("sr_flip_flop: unknown value on s");
  a_r_known : assert property (@(posedge clk) disable iff (!reset) !$isunknown(r))
    else $error("sr_flip_flop: unknown value on r");

endmodule
`default_nettype wire

// File: tb/tb_sr_flip_flop.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sr_flip_flop
//  Description : Self-checking bench. Four 1-bit instances (one per policy)
//                share s1/r1; a 4-bit policy-0 instance uses s4/r4. A
//                behavioural model pushes expected values to a queue as
//                stimulus is driven; each test pops and compares after the edge.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_sr_flip_flop;

  logic       clk = 1'b0;
  logic       reset;
  logic       s1, r1;
  logic [3:0] s4, r4;
  logic [3:0] q_p, qb_p, ill_p;   // bit p = instance with BOTH_POLICY p
  logic [3:0] q4, qb4, ill4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic [3:0] ill;
    logic [3:0] q4;
    logic [3:0] ill4;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_q;
  logic [3:0] m_q4;

  for (genvar p = 0; p < 4; p++) begin : g_pol
    sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_POLICY(p)) u_dut (
      .clk(clk), .reset(reset), .s(s1), .r(r1),
      .q(q_p[p]), .qbar(qb_p[p]), .illegal(ill_p[p])
    );
  end

  sr_flip_flop #(.WIDTH(4), .RESET_VAL(1'b0), .BOTH_POLICY(0)) u_dut4 (
    .clk(clk), .reset(reset), .s(s4), .r(r4),
    .q(q4), .qbar(qb4), .illegal(ill4)
  );

  always #5 clk = ~clk;

  // Truth table of one SR bit
  function automatic logic model_next(input logic qv, input logic sv, input logic rv, input int pol);
    if (sv && !rv) return 1'b1;
    if (!sv && rv) return 1'b0;
    if (!sv && !rv) return qv;
    case (pol)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return ~qv;
      default: return qv;
    endcase
  endfunction

  // Apply inputs and push the expected post-edge outputs
  task automatic drive(input logic sv, input logic rv, input logic [3:0] s4v,
                       input logic [3:0] r4v, input string nm);
    exp_t e;
    s1 = sv; r1 = rv; s4 = s4v; r4 = r4v;
    for (int p = 0; p < 4; p++) m_q[p] = model_next(m_q[p], sv, rv, p);
    for (int b = 0; b < 4; b++) m_q4[b] = model_next(m_q4[b], s4v[b], r4v[b], 0);
    e.name = nm; e.q = m_q; e.ill = {4{sv & rv}}; e.q4 = m_q4; e.ill4 = s4v & r4v;
    sb.push_back(e);
  endtask

  // qbar must equal ~q at all times; sampled off the integer grid to avoid races
  initial begin
    #0.5;
    forever begin
      n_checks++;
      if ((qb_p !== ~q_p) || (qb4 !== ~q4)) begin
        n_fail++;
        $display("FAIL invariant t=%0t: q=%b qbar=%b q4=%b qbar4=%b", $time, q_p, qb_p, q4, qb4);
      end
      #1;
    end
  end

  task automatic test_reset();
    exp_t e;
    reset = 1'b0; s1 = 1'b1; r1 = 1'b0; s4 = 4'hF; r4 = 4'h0;
    m_q = 4'h0; m_q4 = 4'h0;
    #1;
    n_checks++;
    if (q_p !== 4'h0 || qb_p !== 4'hF || ill_p !== 4'h0 || q4 !== 4'h0 || ill4 !== 4'h0) begin
      n_fail++; $display("FAIL reset_t1: q=%b qbar=%b ill=%b q4=%b ill4=%b want 0000 1111 0000 0000 0000", q_p, qb_p, ill_p, q4, ill4);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (q_p !== 4'h0 || qb_p !== 4'hF || ill_p !== 4'h0 || q4 !== 4'h0 || ill4 !== 4'h0) begin
        n_fail++; $display("FAIL reset_hold%0d: q=%b qbar=%b ill=%b q4=%b ill4=%b want all clear", k, q_p, qb_p, ill_p, q4, ill4);
      end
    end
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'hF, 4'h0, "reset_release_set");
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (q_p !== 4'hF || q_p !== e.q) begin n_fail++; $display("FAIL %s q: got %b want %b", e.name, q_p, e.q); end
    n_checks++;
    if (q4 !== e.q4) begin n_fail++; $display("FAIL %s q4: got %b want %b", e.name, q4, e.q4); end
  endtask

  task automatic test_basic();
    logic [1:0] v [5];
    logic       want_q0 [5];
    logic       want_i0 [5];
    exp_t       e;
    v       = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
    want_q0 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    want_i0 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive(v[k][1], v[k][0], 4'h0, 4'h0, $sformatf("basic%0d", k));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (q_p !== e.q) begin n_fail++; $display("FAIL %s q: got %b want %b", e.name, q_p, e.q); end
      n_checks++;
      if (ill_p !== e.ill) begin n_fail++; $display("FAIL %s illegal: got %b want %b", e.name, ill_p, e.ill); end
      n_checks++;
      if (q_p[0] !== want_q0[k] || ill_p[0] !== want_i0[k]) begin
        n_fail++; $display("FAIL %s pol0: q=%b ill=%b want q=%b ill=%b", e.name, q_p[0], ill_p[0], want_q0[k], want_i0[k]);
      end
    end
  endtask

  task automatic test_policy();
    logic [3:0] want [3];
    exp_t       e;
    want = '{4'b1010, 4'b0010, 4'b1010};   // {pol3,pol2,pol1,pol0}
    drive(1'b0, 1'b1, 4'h0, 4'h0, "policy_clear");
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (q_p !== e.q) begin n_fail++; $display("FAIL %s q: got %b want %b", e.name, q_p, e.q); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 4'h0, 4'h0, $sformatf("policy_both%0d", k));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (q_p !== e.q || q_p !== want[k]) begin n_fail++; $display("FAIL %s q: got %b want %b", e.name, q_p, want[k]); end
      n_checks++;
      if (ill_p !== 4'hF) begin n_fail++; $display("FAIL %s illegal: got %b want 1111", e.name, ill_p); end
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, "policy_flag_clear");
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (ill_p !== e.ill || q_p !== e.q) begin n_fail++; $display("FAIL %s: q=%b ill=%b want q=%b ill=%b", e.name, q_p, ill_p, e.q, e.ill); end
  endtask

  task automatic test_multibit();
    exp_t e;
    drive(1'b0, 1'b0, 4'b1100, 4'b0011, "multi_load");
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (q4 !== e.q4) begin n_fail++; $display("FAIL %s q4: got %b want %b", e.name, q4, e.q4); end
    drive(1'b0, 1'b0, 4'b0101, 4'b0011, "multi_mix");
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (q4 !== 4'b1100 || q4 !== e.q4) begin n_fail++; $display("FAIL %s q4: got %b want 1100", e.name, q4); end
    n_checks++;
    if (qb4 !== 4'b0011) begin n_fail++; $display("FAIL %s qbar4: got %b want 0011", e.name, qb4); end
    n_checks++;
    if (ill4 !== 4'b0001 || ill4 !== e.ill4) begin n_fail++; $display("FAIL %s ill4: got %b want 0001", e.name, ill4); end
  endtask

  task automatic test_edge_only();
    exp_t e;
    drive(1'b0, 1'b1, 4'h0, 4'h0, "edge_clear");
    @(posedge clk); #1;
    e = sb.pop_front();
    drive(1'b0, 1'b0, 4'h0, 4'h0, "edge_glitch");
    #2; s1 = 1'b1; s4 = 4'hF;
    #2; s1 = 1'b0; s4 = 4'h0;
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (q_p !== 4'h0 || q_p !== e.q || q4 !== e.q4) begin
      n_fail++; $display("FAIL %s: q=%b q4=%b want q=%b q4=%b", e.name, q_p, q4, e.q, e.q4);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive(1'b1, 1'b0, 4'hF, 4'h0, "async_set");
    @(posedge clk); #1;
    e = sb.pop_front();
    drive(1'b1, 1'b1, 4'hF, 4'hF, "async_both");
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (q_p !== e.q || ill_p !== 4'hF) begin n_fail++; $display("FAIL %s: q=%b ill=%b want q=%b ill=1111", e.name, q_p, ill_p, e.q); end
    #2; reset = 1'b0; s1 = 1'b1; r1 = 1'b0; s4 = 4'hF; r4 = 4'h0;
    #1;
    n_checks++;
    if (q_p !== 4'h0 || qb_p !== 4'hF || ill_p !== 4'h0 || q4 !== 4'h0 || ill4 !== 4'h0) begin
      n_fail++; $display("FAIL async_mid: q=%b qbar=%b ill=%b q4=%b ill4=%b want all clear", q_p, qb_p, ill_p, q4, ill4);
    end
    @(posedge clk); #1;
    n_checks++;
    if (q_p !== 4'h0 || q4 !== 4'h0) begin n_fail++; $display("FAIL async_hold: q=%b q4=%b want 0000 0000", q_p, q4); end
    reset = 1'b1; m_q = 4'h0; m_q4 = 4'h0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 40; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $sformatf("b2b%0d", k));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (q_p !== e.q || ill_p !== e.ill) begin
        n_fail++; $display("FAIL %s: q=%b ill=%b want q=%b ill=%b", e.name, q_p, ill_p, e.q, e.ill);
      end
      n_checks++;
      if (q4 !== e.q4 || ill4 !== e.ill4) begin
        n_fail++; $display("FAIL %s wide: q4=%b ill4=%b want q4=%b ill4=%b", e.name, q4, ill4, e.q4, e.ill4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_policy();
    test_multibit();
    test_edge_only();
    test_async_reset();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 ns, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
